lcd_bus_engine: RTL and testbench
=================================

LCD_BUS_ENGINE -- requirements
Module: lcd_bus_engine

Interface
REQ-001 SHALL have parameter BUS_W, default 16, panel bus width, legal values 8 or 16.
REQ-002 SHALL have parameter DEPTH, default 16, command FIFO entries, power of two, minimum 2.
REQ-003 SHALL have parameters WR_LO 1, WR_HI 1, RD_LO 4, RD_HI 2, giving strobe phase lengths in clk cycles, each at least 1.
REQ-004 SHALL have port clk  in  1  system clock; one clock only.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_dc in 1 (0=LCD_CMD, 1=LCD_DATA), in_rd in 1 (read request), in_data in 16: the request stream.
REQ-007 SHALL have ports rd_valid out 1, rd_data out 16 (readback), busy out 1 (FIFO non-empty or bus active).
REQ-008 SHALL have ports lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n out 1; lcd_d_out out BUS_W; lcd_d_oe out 1; lcd_d_in in BUS_W.

Function
REQ-009 SHALL accept an entry when in_valid and in_ready are both high; in_ready SHALL equal FIFO not-full, with no same-cycle pass-through.
REQ-010 SHALL run state machine IDLE -> FETCH -> SETUP -> LO -> HI -> {SETUP if more bytes/entries, else RELEASE} -> IDLE.
REQ-011 Entry accepted in cycle 0 on an idle engine: FETCH pops it in cycle 1; SETUP in cycle 2 drives lcd_cs_n=0, lcd_rs=in_dc and lcd_d_out.
REQ-012 LO SHALL hold lcd_wr_n low (or lcd_rd_n for reads) for WR_LO (RD_LO) cycles; HI SHALL hold strobes high for WR_HI (RD_HI) cycles.
REQ-013 lcd_rs and lcd_d_out SHALL remain stable from SETUP through the end of HI.
REQ-014 lcd_cs_n SHALL stay low across back-to-back entries while the FIFO is non-empty at the end of HI; RELEASE SHALL drive lcd_cs_n=1 for exactly one cycle.
REQ-015 With BUS_W=8, a write entry SHALL produce two transfers, in_data[15:8] then in_data[7:0], each with its own SETUP/LO/HI.
REQ-016 A read entry SHALL drive lcd_d_oe=0 from SETUP to the end of HI, and sample lcd_d_in in the last LO cycle.
REQ-017 rd_valid SHALL pulse for exactly one cycle, the first HI cycle, with rd_data holding the zero-extended sample until the next read.
REQ-018 With BUS_W=8, a read SHALL be a single byte transfer.
REQ-019 lcd_d_oe SHALL be 1 in every cycle not covered by REQ-016.
REQ-020 Counters SHALL be sized to clog2(max phase + 1) bits and SHALL never wrap.

Reset
REQ-021 While rst is high, the block SHALL flush the FIFO, drop any in-flight entry, and enter IDLE.
REQ-022 While rst is high: in_ready=0, busy=0, rd_valid=0, rd_data=0.
REQ-023 While rst is high: lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=0, lcd_d_out=0, lcd_d_oe=1.
REQ-024 A reset asserted mid-strobe SHALL return all panel strobes high in the next cycle, with no partial transfer resumed.

Configuration
REQ-025 Macro LCD_BUS_READ_EN defined SHALL compile in the read path (REQ-016 to REQ-018).
REQ-026 Without LCD_BUS_READ_EN, in_rd SHALL be ignored (entry executes as a write), lcd_rd_n tied 1, lcd_d_oe tied 1, rd_valid and rd_data tied 0.

Structure
REQ-027 Package lcd_bus_pkg SHALL hold the state enum, LCD_CMD/LCD_DATA constants and the FIFO entry struct {rd, dc, data[15:0]}.
REQ-028 FIFO SHALL be the sub-module lcd_bus_fifo (synchronous, registered read, full/empty flags).

Verification
REQ-029 BUS_W=16, WR 1/1: cmd 0x002A accepted at cycle 0 -> lcd_cs_n low cycles 2-4, lcd_wr_n low cycle 3, lcd_rs=0, lcd_d_out=0x002A, lcd_cs_n high cycle 5.
REQ-030 BUS_W=8: data 0xF81F -> two wr_n pulses, lcd_d_out 0xF8 then 0x1F, lcd_rs=1, one cs_n window.
REQ-031 DEPTH=4, push 6 entries with the engine stalled by WR_LO=8 -> in_ready low after the 4th push (5th accepted after first pop), all 6 emitted in order with cs_n continuously low.
REQ-032 Read with lcd_d_in=0x0052, RD 4/2 -> lcd_rd_n low 4 cycles, lcd_d_oe=0, rd_valid one cycle with rd_data=0x0052; without macro, no rd_n pulse and rd_valid stays 0.
REQ-033 rst pulsed during LO of the 2nd of 3 queued writes -> next cycle all strobes and cs_n high, busy=0, no further wr_n pulses.
REQ-034 Simultaneous push on full FIFO and pop in the same cycle -> entry not accepted (in_ready=0 that cycle), no data loss or duplication.

Source files
------------

// File: rtl/lcd_bus_pkg.sv
// Shared types for the LCD parallel-bus engine.
//   lcd_state_e  : engine state machine encoding
//   LCD_CMD/DATA : values carried on the dc flag (drives lcd_rs)
//   lcd_entry_t  : one queued request {rd, dc, data[15:0]}
//   max4()       : elaboration-time helper used to size the phase counter
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SETUP,
        ST_LO,
        ST_HI,
        ST_RELEASE
    } lcd_state_e;

    localparam logic LCD_CMD  = 1'b0;
    localparam logic LCD_DATA = 1'b1;

    typedef struct packed {
        logic        rd;
        logic        dc;
        logic [15:0] data;
    } lcd_entry_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_bus_fifo.sv
// Command FIFO for the LCD bus engine: synchronous, registered read port.
// pop_entry updates on the clock edge where pop is taken and then holds
// until the next pop, so the engine can use it directly as the current entry.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (flushes)
//   push, push_entry    : write side (ignored when full)
//   pop, pop_entry      : read side (ignored when empty)
//   full, empty         : occupancy flags
module lcd_bus_fifo
    import lcd_bus_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  lcd_entry_t push_entry,
    input  logic       pop,
    output lcd_entry_t pop_entry,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    lcd_entry_t      mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pop_entry <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop && !empty) begin
                pop_entry <= mem[rd_ptr[AW-1:0]];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_engine.sv
// 8080-style LCD parallel-bus engine. Requests are queued in a FIFO and
// replayed onto the panel bus as SETUP / strobe-low / strobe-high phases,
// keeping chip select low across back-to-back entries.
// Optional feature: define LCD_BUS_READ_EN to compile in the read path
// (lcd_rd_n strobe, lcd_d_oe turnaround, rd_valid/rd_data readback).
// Without it, in_rd is ignored and every entry executes as a write.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : request handshake (in_ready = FIFO not full)
//   in_dc, in_rd, in_data         : request fields (dc drives lcd_rs)
//   rd_valid, rd_data             : one-cycle readback pulse and held sample
//   busy                          : FIFO non-empty or bus transaction active
//   lcd_cs_n, lcd_rs, lcd_wr_n,
//   lcd_rd_n, lcd_d_out, lcd_d_oe : panel bus outputs
//   lcd_d_in                      : panel bus input data
module lcd_bus_engine
    import lcd_bus_pkg::*;
#(
    parameter int BUS_W = 16,
    parameter int DEPTH = 16,
    parameter int WR_LO = 1,
    parameter int WR_HI = 1,
    parameter int RD_LO = 4,
    parameter int RD_HI = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dc,
    input  logic             in_rd,
    input  logic [15:0]      in_data,
    output logic             rd_valid,
    output logic [15:0]      rd_data,
    output logic             busy,
    output logic             lcd_cs_n,
    output logic             lcd_rs,
    output logic             lcd_wr_n,
    output logic             lcd_rd_n,
    output logic [BUS_W-1:0] lcd_d_out,
    output logic             lcd_d_oe,
    input  logic [BUS_W-1:0] lcd_d_in
);

    localparam int MAX_PH = max4(WR_LO, WR_HI, RD_LO, RD_HI);
    localparam int CNT_W  = $clog2(MAX_PH + 1);

    // Phase counter counts 0..len-1; the phase ends on the terminal value.
    localparam logic [CNT_W-1:0] WR_LO_END = CNT_W'(WR_LO - 1);
    localparam logic [CNT_W-1:0] WR_HI_END = CNT_W'(WR_HI - 1);
    localparam logic [CNT_W-1:0] RD_LO_END = CNT_W'(RD_LO - 1);
    localparam logic [CNT_W-1:0] RD_HI_END = CNT_W'(RD_HI - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    lcd_state_e       state;
    lcd_state_e       state_d;
    lcd_entry_t       push_entry;
    lcd_entry_t       cur;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] cnt;
    logic             byte_sel;
    logic             byte_sel_d;
    logic             is_read;
    logic             two_byte;
    logic             lo_done;
    logic             hi_done;
    logic             active;
    logic [15:0]      word;

    assign in_ready   = !full && !rst;
    assign push       = in_valid && in_ready;
    assign push_entry = '{rd: in_rd, dc: in_dc, data: in_data};

    lcd_bus_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .pop_entry (cur),
        .full      (full),
        .empty     (empty)
    );

    // On an 8-bit bus a write goes out as high byte, then low byte.
    assign two_byte = (BUS_W == 8) && !is_read;
    assign lo_done  = (cnt == (is_read ? RD_LO_END : WR_LO_END));
    assign hi_done  = (cnt == (is_read ? RD_HI_END : WR_HI_END));
    assign active   = (state == ST_SETUP) || (state == ST_LO) || (state == ST_HI);
    assign word     = (two_byte && !byte_sel) ? {8'h00, cur.data[15:8]} : cur.data;
    assign busy     = !rst && (!empty || (state != ST_IDLE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic. IDLE also reacts to a push in the same cycle so the
    // entry is popped in FETCH one cycle after acceptance. The next entry is
    // popped on the last HI cycle so SETUP follows HI without a FETCH gap.
    always_comb begin
        state_d    = state;
        pop        = 1'b0;
        byte_sel_d = byte_sel;
        case (state)
            ST_IDLE: begin
                if (!empty || push) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                pop        = 1'b1;
                byte_sel_d = 1'b0;
                state_d    = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_LO;
            end
            ST_LO: begin
                if (lo_done) state_d = ST_HI;
            end
            ST_HI: begin
                if (hi_done) begin
                    if (two_byte && !byte_sel) begin
                        byte_sel_d = 1'b1;
                        state_d    = ST_SETUP;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        byte_sel_d = 1'b0;
                        state_d    = ST_SETUP;
                    end else begin
                        byte_sel_d = 1'b0;
                        state_d    = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Phase counter and byte selector; the counter clears on every phase
    // exit, so it never reaches beyond the longest phase length.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            byte_sel <= 1'b0;
        end else begin
            byte_sel <= byte_sel_d;
            if (((state == ST_LO) && !lo_done) || ((state == ST_HI) && !hi_done)) begin
                cnt <= cnt + CNT_ONE;
            end else begin
                cnt <= '0;
            end
        end
    end

    // Output logic. Reset forces the bus idle immediately, so a strobe cut
    // by reset returns high without waiting for the state register.
    always_comb begin
        lcd_cs_n  = 1'b1;
        lcd_rs    = 1'b0;
        lcd_wr_n  = 1'b1;
        lcd_rd_n  = 1'b1;
        lcd_d_out = '0;
        lcd_d_oe  = 1'b1;
        if (!rst && active) begin
            lcd_cs_n  = 1'b0;
            lcd_rs    = cur.dc;
            lcd_d_out = word[BUS_W-1:0];
            lcd_d_oe  = !is_read;
            if (state == ST_LO) begin
                if (is_read) begin
                    lcd_rd_n = 1'b0;
                end else begin
                    lcd_wr_n = 1'b0;
                end
            end
        end
    end

`ifdef LCD_BUS_READ_EN
    logic        rd_valid_q;
    logic [15:0] rd_data_q;
    logic        rd_sample;

    // Sample on the last LO cycle; the pulse lands on the first HI cycle.
    assign is_read   = cur.rd;
    assign rd_sample = (state == ST_LO) && lo_done && is_read;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_sample;
            if (rd_sample) begin
                rd_data_q <= 16'(lcd_d_in);
            end
        end
    end

    assign rd_valid = rd_valid_q && !rst;
    assign rd_data  = rst ? 16'h0000 : rd_data_q;
`else
    logic unused_ok;

    assign is_read   = 1'b0;
    assign rd_valid  = 1'b0;
    assign rd_data   = 16'h0000;
    assign unused_ok = ^{cur.rd, lcd_d_in};
`endif

endmodule

// File: tb/tb_lcd_bus_engine.sv
// Directed bench for lcd_bus_engine: three instances (16-bit default,
// 8-bit bus, 4-deep FIFO with a long write strobe) sharing clk and rst.
`timescale 1ns/1ps
module tb_lcd_bus_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance a: BUS_W=16, default timing
    logic        a_valid, a_ready, a_dc, a_rd, a_rdv, a_busy;
    logic        a_cs, a_rs, a_wr, a_rdn, a_oe;
    logic [15:0] a_data, a_rdd, a_dout, a_din;

    // Instance b: BUS_W=8
    logic        b_valid, b_ready, b_dc, b_rd, b_rdv, b_busy;
    logic        b_cs, b_rs, b_wr, b_rdn, b_oe;
    logic [15:0] b_data, b_rdd;
    logic [7:0]  b_dout, b_din;

    // Instance c: DEPTH=4, WR_LO=8
    logic        c_valid, c_ready, c_dc, c_rd, c_rdv, c_busy;
    logic        c_cs, c_rs, c_wr, c_rdn, c_oe;
    logic [15:0] c_data, c_rdd, c_dout, c_din;

    lcd_bus_engine #(.BUS_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_dc(a_dc),
        .in_rd(a_rd), .in_data(a_data), .rd_valid(a_rdv), .rd_data(a_rdd), .busy(a_busy),
        .lcd_cs_n(a_cs), .lcd_rs(a_rs), .lcd_wr_n(a_wr), .lcd_rd_n(a_rdn),
        .lcd_d_out(a_dout), .lcd_d_oe(a_oe), .lcd_d_in(a_din)
    );

    lcd_bus_engine #(.BUS_W(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_dc(b_dc),
        .in_rd(b_rd), .in_data(b_data), .rd_valid(b_rdv), .rd_data(b_rdd), .busy(b_busy),
        .lcd_cs_n(b_cs), .lcd_rs(b_rs), .lcd_wr_n(b_wr), .lcd_rd_n(b_rdn),
        .lcd_d_out(b_dout), .lcd_d_oe(b_oe), .lcd_d_in(b_din)
    );

    lcd_bus_engine #(.BUS_W(16), .DEPTH(4), .WR_LO(8)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_dc(c_dc),
        .in_rd(c_rd), .in_data(c_data), .rd_valid(c_rdv), .rd_data(c_rdd), .busy(c_busy),
        .lcd_cs_n(c_cs), .lcd_rs(c_rs), .lcd_wr_n(c_wr), .lcd_rd_n(c_rdn),
        .lcd_d_out(c_dout), .lcd_d_oe(c_oe), .lcd_d_in(c_din)
    );

    typedef struct {
        logic        dc;
        logic [15:0] data;
        logic        exp_rs;
        logic [15:0] exp_dout;
    } vec_a_t;

    typedef struct {
        logic        dc;
        logic [15:0] data;
        logic        exp_rs;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_b_t;

    vec_a_t va [5];
    vec_b_t vb [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] clist [6];
        logic [15:0] got [6];
        int          acc, stall_k, stall_acc, sixth_k, got_n, cs_low, cs_rise, wr_low;
        logic        ready_k11, prev_wr, prev_cs;

        a_valid = 0; a_dc = 0; a_rd = 0; a_data = '0; a_din = 16'h0052;
        b_valid = 0; b_dc = 0; b_rd = 0; b_data = '0; b_din = 8'h00;
        c_valid = 0; c_dc = 0; c_rd = 0; c_data = '0; c_din = 16'h0000;

        va[0] = '{dc: 1'b0, data: 16'h002A, exp_rs: 1'b0, exp_dout: 16'h002A};
        va[1] = '{dc: 1'b1, data: 16'hF81F, exp_rs: 1'b1, exp_dout: 16'hF81F};
        va[2] = '{dc: 1'b0, data: 16'h0000, exp_rs: 1'b0, exp_dout: 16'h0000};
        va[3] = '{dc: 1'b1, data: 16'hFFFF, exp_rs: 1'b1, exp_dout: 16'hFFFF};
        va[4] = '{dc: 1'b1, data: 16'h1234, exp_rs: 1'b1, exp_dout: 16'h1234};
        vb[0] = '{dc: 1'b1, data: 16'hF81F, exp_rs: 1'b1, exp_hi: 8'hF8, exp_lo: 8'h1F};
        vb[1] = '{dc: 1'b0, data: 16'h00A5, exp_rs: 1'b0, exp_hi: 8'h00, exp_lo: 8'hA5};
        clist = '{16'hA001, 16'hB002, 16'hC003, 16'hD004, 16'hE005, 16'hF006};

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", a_ready, 0);   chk("rst_a_busy", a_busy, 0);
        chk("rst_a_cs", a_cs, 1);         chk("rst_a_wr", a_wr, 1);
        chk("rst_a_rdn", a_rdn, 1);       chk("rst_a_rs", a_rs, 0);
        chk("rst_a_dout", a_dout, 0);     chk("rst_a_oe", a_oe, 1);
        chk("rst_a_rdv", a_rdv, 0);       chk("rst_a_rdd", a_rdd, 0);
        chk("rst_b_ready", b_ready, 0);   chk("rst_b_busy", b_busy, 0);
        chk("rst_b_cs", b_cs, 1);         chk("rst_b_wr", b_wr, 1);
        chk("rst_b_rdn", b_rdn, 1);       chk("rst_b_rs", b_rs, 0);
        chk("rst_b_dout", b_dout, 0);     chk("rst_b_oe", b_oe, 1);
        chk("rst_b_rdv", b_rdv, 0);       chk("rst_b_rdd", b_rdd, 0);
        chk("rst_c_ready", c_ready, 0);   chk("rst_c_busy", c_busy, 0);
        chk("rst_c_cs", c_cs, 1);         chk("rst_c_wr", c_wr, 1);
        chk("rst_c_rdn", c_rdn, 1);       chk("rst_c_rs", c_rs, 0);
        chk("rst_c_dout", c_dout, 0);     chk("rst_c_oe", c_oe, 1);
        chk("rst_c_rdv", c_rdv, 0);       chk("rst_c_rdd", c_rdd, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---- 16-bit single writes: cs_n low 2..4, wr_n low 3, release 5 ----
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1; a_dc = va[i].dc; a_data = va[i].data; a_rd = 1'b0;
            chk("a_ready_c0", a_ready, 1);
            chk("a_busy_c0", a_busy, 0);
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                a_valid = 1'b0;
                chk("a_cs", a_cs, (c >= 2 && c <= 4) ? 0 : 1);
                chk("a_wr", a_wr, (c == 3) ? 0 : 1);
                chk("a_oe", a_oe, 1);
                chk("a_busy", a_busy, (c <= 5) ? 1 : 0);
                if (c >= 2 && c <= 4) begin
                    chk("a_rs", a_rs, 32'(va[i].exp_rs));
                    chk("a_dout", a_dout, 32'(va[i].exp_dout));
                end
            end
        end

        // ---- 8-bit writes: two byte transfers in one cs_n window ----
        for (int i = 0; i < 2; i++) begin
            b_valid = 1'b1; b_dc = vb[i].dc; b_data = vb[i].data;
            for (int c = 1; c <= 9; c++) begin
                @(negedge clk);
                b_valid = 1'b0;
                chk("b_cs", b_cs, (c >= 2 && c <= 7) ? 0 : 1);
                chk("b_wr", b_wr, (c == 3 || c == 6) ? 0 : 1);
                chk("b_busy", b_busy, (c <= 8) ? 1 : 0);
                if (c >= 2 && c <= 4) chk("b_dout_hi", b_dout, 32'(vb[i].exp_hi));
                if (c >= 5 && c <= 7) chk("b_dout_lo", b_dout, 32'(vb[i].exp_lo));
                if (c >= 2 && c <= 7) chk("b_rs", b_rs, 32'(vb[i].exp_rs));
            end
        end

        // ---- read request, lcd_d_in = 0x0052 ----
        a_valid = 1'b1; a_dc = 1'b0; a_rd = 1'b1; a_data = 16'h00A0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            a_valid = 1'b0; a_rd = 1'b0;
`ifdef LCD_BUS_READ_EN
            chk("rd_cs", a_cs, (c >= 2 && c <= 8) ? 0 : 1);
            chk("rd_rdn", a_rdn, (c >= 3 && c <= 6) ? 0 : 1);
            chk("rd_wr", a_wr, 1);
            chk("rd_oe", a_oe, (c >= 2 && c <= 8) ? 0 : 1);
            chk("rd_valid", a_rdv, (c == 7) ? 1 : 0);
            if (c >= 7) chk("rd_data", a_rdd, 32'h0052);
`else
            chk("rd_cs", a_cs, (c >= 2 && c <= 4) ? 0 : 1);
            chk("rd_wr", a_wr, (c == 3) ? 0 : 1);
            chk("rd_rdn", a_rdn, 1);
            chk("rd_oe", a_oe, 1);
            chk("rd_valid", a_rdv, 0);
            chk("rd_data", a_rdd, 0);
`endif
        end

        // ---- DEPTH=4 with WR_LO=8: fill, stall, drain in order ----
        // The first entry is popped one cycle after it is accepted, so the
        // FIFO holds 4 queued entries after the 5th acceptance; the next pop
        // happens at the end of entry 1 HI (cycle 11), so entry 6 goes in
        // at cycle 12. Entries run back to back: 6 x 10 cycles from cycle 2.
        acc = 0; stall_k = -1; stall_acc = -1; sixth_k = -1; ready_k11 = 1'b1;
        got_n = 0; cs_low = 0; cs_rise = 0; prev_wr = 1'b1; prev_cs = 1'b1;
        got = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        c_dc = 1'b1;
        fork
            begin
                for (int k = 0; k < 40 && acc < 6; k++) begin
                    c_valid = 1'b1;
                    c_data  = clist[acc];
                    if (k == 11) ready_k11 = c_ready;
                    if (c_ready) begin
                        acc++;
                        if (acc == 6) sixth_k = k;
                    end else if (stall_k < 0) begin
                        stall_k   = k;
                        stall_acc = acc;
                    end
                    @(negedge clk);
                end
                c_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 70; k++) begin
                    if (!c_cs) cs_low++;
                    if (c_cs && !prev_cs) cs_rise++;
                    if (!c_wr && prev_wr) begin
                        if (got_n < 6) got[got_n] = c_dout;
                        got_n++;
                    end
                    prev_cs = c_cs;
                    prev_wr = c_wr;
                    @(negedge clk);
                end
            end
        join
        chk("c_stall_cycle", stall_k, 5);
        chk("c_accepted_before_stall", stall_acc, 5);
        chk("c_ready_on_pop_cycle", ready_k11, 0);
        chk("c_sixth_accept_cycle", sixth_k, 12);
        chk("c_wr_pulses", got_n, 6);
        for (int i = 0; i < 6; i++) chk("c_order", got[i], clist[i]);
        chk("c_cs_low_cycles", cs_low, 60);
        chk("c_cs_windows", cs_rise, 1);
        chk("c_busy_end", c_busy, 0);

        // ---- reset during LO of the 2nd of 3 queued writes ----
        a_dc = 1'b1; a_rd = 1'b0;
        a_valid = 1'b1; a_data = 16'h1111;
        @(negedge clk); a_data = 16'h2222;
        @(negedge clk); a_data = 16'h3333;
        @(negedge clk); a_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_wr_low", a_wr, 0);
        chk("rst_mid_dout", a_dout, 32'h2222);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_cs", a_cs, 1);
        chk("rst_mid_wr", a_wr, 1);
        chk("rst_mid_rdn", a_rdn, 1);
        chk("rst_mid_busy", a_busy, 0);
        chk("rst_mid_ready", a_ready, 0);
        rst = 1'b0;
        wr_low = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!a_wr || !a_cs) wr_low++;
        end
        chk("rst_no_resume", wr_low, 0);
        chk("rst_busy_after", a_busy, 0);
        chk("rst_ready_after", a_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
